// File: rtl/serial_word_packer.sv
// Packs WIDTH qualified serial bits into words and queues them in a DEPTH-entry
// FIFO with a valid/ready output; overflow flags any completed word that was dropped.
module serial_word_packer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       bit_in_i,
  input  logic                       bit_valid_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       overflow_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LastCnt  = CW'(WIDTH - 1);
  localparam logic [AW:0]   FullFill = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {StCollect, StPush} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             push_req;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fill_q, fill_d;
  logic             overflow_q;
  logic             full, do_push, do_pop, drop;

  // Each new bit enters at the end that leaves the first bit in its final position.
  assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], bit_in_i}
                              : {bit_in_i, shift_q[WIDTH-1:1]};
  assign last_bit = bit_valid_i & ~flush_i & (cnt_q == LastCnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: state_d = last_bit ? StPush : StCollect;
      StPush:    state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_comb begin
    push_req = 1'b0;
    unique case (state_q)
      StPush:  push_req = 1'b1;
      default: push_req = 1'b0;
    endcase
  end

  // Bit collection keeps running during PUSH so back-to-back words lose nothing.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;
    if (flush_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (bit_valid_i) begin
      if (last_bit) begin
        cnt_d   = '0;
        shift_d = '0;
        word_d  = shifted;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        shift_d = shifted;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
    end
  end

  assign full    = (fill_q == FullFill);
  assign do_pop  = out_valid_o & out_ready_i;
  assign do_push = push_req & (~full | do_pop);
  assign drop    = push_req & full & ~do_pop;

  always_comb begin
    fill_d = fill_q;
    unique case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + (AW + 1)'(1);
      2'b01:   fill_d = fill_q - (AW + 1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= word_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign out_data_o  = mem_q[rd_ptr_q];
  assign out_valid_o = (fill_q != '0);
  assign fill_o      = fill_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed bench for serial_word_packer: words are sent bit-serially, expected words
// are queued on send and compared as the sink pops them.
module tb_serial_word_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in, bit_valid, flush, out_ready;
  logic [7:0] out_data;
  logic       out_valid, overflow;
  logic [2:0] fill;

  // Small clocked 2:1 mux model feeding the packer in the mux-chain phase.
  logic mux_mode, sel, sel_vld, mux_q, mux_vld;
  logic drv_bit, drv_vld;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    mux_q   <= sel ? 1'b1 : 1'b0;
    mux_vld <= sel_vld;
  end

  assign bit_in    = mux_mode ? mux_q : drv_bit;
  assign bit_valid = mux_mode ? mux_vld : drv_vld;

  serial_word_packer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bit_in_i    (bit_in),
    .bit_valid_i (bit_valid),
    .flush_i     (flush),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .fill_o      (fill),
    .overflow_o  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop just before the edge that accepts the head word.
  task automatic tick();
    logic [7:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", {24'h0, out_data}, {24'h0, e});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input bit expect_it);
    for (int i = 0; i < 8; i++) begin
      drv_bit = w[i];
      drv_vld = 1'b1;
      tick();
    end
    drv_vld = 1'b0;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) tick();
    out_ready = 1'b0;
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_fill"}, {29'h0, fill}, 0);
  endtask

  initial begin
    rst_n = 1'b0; drv_bit = 1'b0; drv_vld = 1'b0; flush = 1'b0; out_ready = 1'b0;
    mux_mode = 1'b0; sel = 1'b0; sel_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'h0, out_valid}, 0);
    chk("rst_data", {24'h0, out_data}, 0);
    chk("rst_fill", {29'h0, fill}, 0);
    chk("rst_ovf", {31'h0, overflow}, 0);
    rst_n = 1'b1;
    tick();

    // Basic pack and two-cycle latency.
    send_word(8'h8D, 1'b1);
    chk("lat_push_cycle", {31'h0, out_valid}, 0);
    tick();
    chk("lat_valid", {31'h0, out_valid}, 1);
    chk("pack_data", {24'h0, out_data}, 32'h8D);
    chk("pack_fill", {29'h0, fill}, 1);

    // Reset mid-word with a word already queued.
    for (int i = 0; i < 5; i++) begin
      drv_bit = 1'b1; drv_vld = 1'b1; tick();
    end
    drv_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, out_valid}, 0);
    chk("midrst_data", {24'h0, out_data}, 0);
    chk("midrst_fill", {29'h0, fill}, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'h3C, 1'b1);
    tick();
    chk("postrst_data", {24'h0, out_data}, 32'h3C);
    drain("postrst");

    // Fill to capacity, then overflow.
    send_word(8'hA5, 1'b1);
    send_word(8'h3C, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    tick(); tick();
    chk("full_fill", {29'h0, fill}, 4);
    chk("full_ovf", {31'h0, overflow}, 0);
    chk("hold_data", {24'h0, out_data}, 32'hA5);
    send_word(8'h77, 1'b0);
    tick(); tick();
    chk("drop_ovf", {31'h0, overflow}, 1);
    chk("drop_fill", {29'h0, fill}, 4);

    // Push into a full FIFO while the sink pops in the same cycle.
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'hA5, 1'b1);
    send_word(8'h3C, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    send_word(8'h5A, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("conc_fill", {29'h0, fill}, 4);
    chk("conc_ovf", {31'h0, overflow}, 0);
    drain("conc");

    // Gapped bit_valid: unqualified cycles carry the opposite bit value.
    for (int i = 0; i < 8; i++) begin
      drv_bit = ~(((8'hC3) >> i) & 1'b1); drv_vld = 1'b0; tick();
      drv_bit = ((8'hC3) >> i) & 1'b1;    drv_vld = 1'b1; tick();
    end
    drv_vld = 1'b0;
    exp_q.push_back(8'hC3);
    tick(); tick();
    drain("gaps");

    // Flush after three bits, with a concurrent valid bit that must be discarded.
    for (int i = 0; i < 3; i++) begin
      drv_bit = 1'b1; drv_vld = 1'b1; tick();
    end
    flush = 1'b1; tick();
    flush = 1'b0; drv_vld = 1'b0;
    send_word(8'h12, 1'b1);
    tick(); tick();
    chk("flush_data", {24'h0, out_data}, 32'h12);
    drain("flush");

    // Clocked mux chain: d_in0=0, d_in1=1, alternating select.
    mux_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = (i % 2 == 0); sel_vld = 1'b1; tick();
    end
    sel_vld = 1'b0;
    exp_q.push_back(8'h55);
    tick(); tick(); tick();
    chk("mux_valid", {31'h0, out_valid}, 1);
    drain("mux");
    chk("final_ovf", {31'h0, overflow}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
